coax_tx_predistorter: RTL and testbench
=======================================

// Module: coax_tx_predistorter
// PURPOSE
//  Generates the three coax line-driver signals (data, delayed data, inverted data) from the serial TX bitstream for pre-emphasis.
//  Successor to the fixed quarter-bit distorter, adding:
//   - a runtime-programmable delay;
//   - per-output enables;
//   - a post-frame TAIL hold that keeps the driver active while the line settles.
//  Sits between coax_tx (serialiser) and the output pins/driver.
// PARAMETERS
//  CLOCKS_PER_BIT    8   clocks per coax bit cell
//  MAX_DELAY_CLOCKS  8   depth of delay line; largest programmable delay (>=1)
//  TAIL_CLOCKS       4   clocks active_output stays high after active_input falls (0 = no tail)
//  DELAY_W           $clog2(MAX_DELAY_CLOCKS+1)   width of cfg_delay
// PORTS
//  clk            in   1        system clock; single clock domain
//  reset          in   1        synchronous, active-high reset
//  active_input   in   1        serialiser driving line
//  tx_input       in   1        serial bitstream, valid while active_input=1
//  cfg_load       in   1        strobe: latch cfg_* (accepted only when cfg_busy=0)
//  cfg_delay      in   DELAY_W  delay of tx_delay vs tx_output, in clocks
//  cfg_delay_en   in   1        1 = drive tx_delay; 0 = force tx_delay=0
//  cfg_invert_en  in   1        1 = drive tx_inverted; 0 = force tx_inverted=0
//  cfg_busy       out  1        1 when state != IDLE; cfg_load ignored
//  active_output  out  1        line-driver enable
//  tx_output      out  1        registered tx_input
//  tx_delay       out  1        tx_input delayed by cfg_delay clocks
//  tx_inverted    out  1        ~tx_input
// BEHAVIOUR
//  - All outputs registered; latency 1 clk from active_input/tx_input to outputs.
//  - Reset: state=IDLE. Outputs 0 (active_output, tx_output, tx_delay, tx_inverted, cfg_busy).
//    Config regs reset to delay=CLOCKS_PER_BIT/4, delay_en=1, invert_en=1. Delay line all 1s.
//  - Reset mid-frame: all of the above take effect next edge; no tail is generated.
//  - FSM: IDLE, RUN, TAIL.
//  - IDLE:
//     - outputs 0; delay line held at all 1s (line idles high).
//     - cfg_load=1 latches cfg_*; cfg_delay > MAX_DELAY_CLOCKS is clamped to MAX_DELAY_CLOCKS.
//     - active_input=1 -> RUN.
//     - cfg_load and active_input in the same cycle: config is latched AND applies from the first RUN output.
//  - RUN:
//     - line shifts in tx_input each clk.
//     - active_output=1, tx_output=tx_input, tx_inverted=~tx_input&invert_en.
//     - tx_delay = (delay==0 ? tx_input : line tap[delay-1]) & delay_en.
//       First `delay` clocks of a frame therefore emit the preset 1s.
//     - active_input=0 -> TAIL (TAIL_CLOCKS>0) else IDLE.
//  - TAIL:
//     - counter loads TAIL_CLOCKS-1 on entry and counts down.
//     - active_output=1; tx_output/tx_inverted hold the last RUN values.
//     - line keeps shifting, fed with the last tx_input, so tx_delay drains.
//     - count 0 -> IDLE.
//     - active_input=1 in TAIL -> RUN next clk; delay line NOT re-preset (frame is continuous).
//  - cfg_busy=1 in RUN and TAIL; cfg_load there is dropped, not queued.
//  - Tail counter width $clog2(TAIL_CLOCKS+1), min 1; no wrap (saturates at 0 in IDLE).
// STRUCTURE
//  - Shared include coax_defs.vh: state encodings (IDLE=0,RUN=1,TAIL=2), CLOCKS_PER_BIT default.
//  - Sub-module coax_tx_delay_line: params DEPTH, PRESET.
//    Ports clk, preset, shift, d, tap_sel, q; returns d when tap_sel==0.
//  - Top holds FSM, tail counter, config regs, output regs.
// TESTING (CLOCKS_PER_BIT=8, MAX_DELAY_CLOCKS=8, TAIL_CLOCKS=4)
//  1. Reset defaults: active 16 clks, tx_input=1010.. per 8 clks.
//     -> tx_delay = tx_output shifted 2 clks; first 2 tx_delay=1; outputs lag inputs by 1 clk.
//  2. cfg_load delay=5 in IDLE, then frame -> tx_delay lags tx_output by 5 clks.
//     cfg_delay=15 -> clamps to 8.
//  3. cfg_delay=0 -> tx_delay==tx_output every clk.
//     delay_en=0 / invert_en=0 -> tx_delay / tx_inverted stay 0 for whole frame.
//  4. active_input falls with last bit=0 -> active_output high 4 more clks, tx_output=0, tx_inverted=1.
//     Then all outputs 0, cfg_busy=0.
//  5. active_input reasserts on TAIL clk 2 -> RUN, no preset 1s in tx_delay.
//     cfg_load during RUN/TAIL -> config unchanged.
//  6. reset asserted mid-RUN -> next clk all outputs 0, state IDLE, no tail; config back to defaults.

Source files
------------

// File: rtl/coax_tx_predistorter_pkg.sv
// Shared definitions for the coax TX pre-distorter.
// Contents:
//   coax_state_e     FSM state encoding (IDLE=0, RUN=1, TAIL=2)
//   CLOCKS_PER_BIT_D default coax bit-cell length in clocks
//   cnt_width()      width of a down-counter that must hold values 0..n (min 1)
package coax_tx_predistorter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TAIL = 2'd2
  } coax_state_e;

  localparam int CLOCKS_PER_BIT_D = 8;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/coax_tx_predistorter_delay_line.sv
// coax_tx_delay_line: shift register with a selectable tap.
// Ports:
//   clk      system clock
//   preset   load every stage with PRESET (has priority over shift)
//   shift    shift d into stage 0, older samples move towards DEPTH-1
//   d        serial input
//   tap_sel  0 selects d itself, k selects the sample shifted in k clocks ago
//   q        selected tap (combinational)
module coax_tx_delay_line #(
  parameter int   DEPTH  = 8,
  parameter logic PRESET = 1'b1
) (
  input  logic                         clk,
  input  logic                         preset,
  input  logic                         shift,
  input  logic                         d,
  input  logic [$clog2(DEPTH+1)-1:0]   tap_sel,
  output logic                         q
);

  localparam int SEL_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] line_q;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (preset) begin
          line_q[gi] <= PRESET;
        end else if (shift) begin
          if (gi == 0) begin
            line_q[gi] <= d;
          end else begin
            line_q[gi] <= line_q[gi-1];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    q = d;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == SEL_W'(i + 1)) begin
        q = line_q[i];
      end
    end
    // Out-of-range selects read the oldest stage rather than wrapping.
    if (tap_sel > SEL_W'(DEPTH)) begin
      q = line_q[DEPTH-1];
    end
  end

endmodule

// File: rtl/coax_tx_predistorter.sv
// coax_tx_predistorter: builds the three coax line-driver signals (data,
// delayed data, inverted data) from the serial TX bitstream, with a
// programmable delay, per-output enables and a post-frame tail hold.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   active_input    serialiser is driving the line
//   tx_input        serial bit, valid while active_input=1
//   cfg_load        latch cfg_* (only while idle)
//   cfg_delay       tx_delay lag in clocks (clamped to MAX_DELAY_CLOCKS)
//   cfg_delay_en    enable for tx_delay
//   cfg_invert_en   enable for tx_inverted
//   cfg_busy        frame or tail in progress; cfg_load dropped
//   active_output   line-driver enable
//   tx_output       registered data
//   tx_delay        data delayed by the configured number of clocks
//   tx_inverted     inverted data
module coax_tx_predistorter
  import coax_tx_predistorter_pkg::*;
#(
  parameter int CLOCKS_PER_BIT   = CLOCKS_PER_BIT_D,
  parameter int MAX_DELAY_CLOCKS = 8,
  parameter int TAIL_CLOCKS      = 4,
  parameter int DELAY_W          = $clog2(MAX_DELAY_CLOCKS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               active_input,
  input  logic               tx_input,
  input  logic               cfg_load,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic               cfg_delay_en,
  input  logic               cfg_invert_en,
  output logic               cfg_busy,
  output logic               active_output,
  output logic               tx_output,
  output logic               tx_delay,
  output logic               tx_inverted
);

  localparam int TCNT_W = cnt_width(TAIL_CLOCKS);
  localparam logic [DELAY_W-1:0] DELAY_MAX = DELAY_W'(MAX_DELAY_CLOCKS);
  localparam logic [DELAY_W-1:0] DELAY_RST = DELAY_W'(CLOCKS_PER_BIT / 4);
  localparam logic [TCNT_W-1:0]  TAIL_LOAD = TCNT_W'((TAIL_CLOCKS > 0) ? TAIL_CLOCKS - 1 : 0);

  coax_state_e         state_q, state_d;
  logic [TCNT_W-1:0]   tail_cnt_q, tail_cnt_d;
  logic [DELAY_W-1:0]  delay_q, delay_d;
  logic                delay_en_q, delay_en_d;
  logic                invert_en_q, invert_en_d;
  logic                active_q, active_d;
  logic                tx_out_q, tx_out_d;
  logic                tx_dly_q, tx_dly_d;
  logic                tx_inv_q, tx_inv_d;

  logic                cfg_take;
  logic [DELAY_W-1:0]  cfg_delay_clamped;
  logic [DELAY_W-1:0]  eff_delay;
  logic                eff_delay_en;
  logic                eff_invert_en;
  logic                line_preset_comb;
  logic                line_preset;
  logic                line_shift;
  logic                line_d;
  logic                line_q;

  // A load coinciding with the first active cycle must already shape that
  // cycle's outputs, so the datapath reads the incoming config directly.
  assign cfg_take          = (state_q == ST_IDLE) && cfg_load;
  assign cfg_delay_clamped = (cfg_delay > DELAY_MAX) ? DELAY_MAX : cfg_delay;
  assign eff_delay         = cfg_take ? cfg_delay_clamped : delay_q;
  assign eff_delay_en      = cfg_take ? cfg_delay_en      : delay_en_q;
  assign eff_invert_en     = cfg_take ? cfg_invert_en     : invert_en_q;

  assign line_preset = reset | line_preset_comb;

  coax_tx_delay_line #(
    .DEPTH  (MAX_DELAY_CLOCKS),
    .PRESET (1'b1)
  ) u_delay_line (
    .clk     (clk),
    .preset  (line_preset),
    .shift   (line_shift),
    .d       (line_d),
    .tap_sel (eff_delay),
    .q       (line_q)
  );

  always_comb begin
    state_d          = state_q;
    tail_cnt_d       = tail_cnt_q;
    delay_d          = delay_q;
    delay_en_d       = delay_en_q;
    invert_en_d      = invert_en_q;
    active_d         = 1'b0;
    tx_out_d         = 1'b0;
    tx_dly_d         = 1'b0;
    tx_inv_d         = 1'b0;
    line_preset_comb = 1'b0;
    line_shift       = 1'b0;
    line_d           = tx_out_q;

    if (cfg_take) begin
      delay_d     = cfg_delay_clamped;
      delay_en_d  = cfg_delay_en;
      invert_en_d = cfg_invert_en;
    end

    if (active_input) begin
      // Entering or staying in RUN, including a re-start out of TAIL, which
      // continues the frame without re-presetting the line.
      state_d    = ST_RUN;
      tail_cnt_d = '0;
      active_d   = 1'b1;
      tx_out_d   = tx_input;
      tx_inv_d   = ~tx_input & eff_invert_en;
      tx_dly_d   = line_q & eff_delay_en;
      line_shift = 1'b1;
      line_d     = tx_input;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (TAIL_CLOCKS > 0) begin
            state_d    = ST_TAIL;
            tail_cnt_d = TAIL_LOAD;
            active_d   = 1'b1;
            tx_out_d   = tx_out_q;
            tx_inv_d   = tx_inv_q;
            tx_dly_d   = line_q & eff_delay_en;
            line_shift = 1'b1;
          end else begin
            state_d          = ST_IDLE;
            line_preset_comb = 1'b1;
          end
        end
        ST_TAIL: begin
          if (tail_cnt_q == '0) begin
            state_d          = ST_IDLE;
            line_preset_comb = 1'b1;
          end else begin
            // Keep the driver on and drain the delay line with the last bit.
            tail_cnt_d = tail_cnt_q - 1'b1;
            active_d   = 1'b1;
            tx_out_d   = tx_out_q;
            tx_inv_d   = tx_inv_q;
            tx_dly_d   = line_q & eff_delay_en;
            line_shift = 1'b1;
          end
        end
        default: begin
          state_d          = ST_IDLE;
          line_preset_comb = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tail_cnt_q  <= '0;
      delay_q     <= DELAY_RST;
      delay_en_q  <= 1'b1;
      invert_en_q <= 1'b1;
      active_q    <= 1'b0;
      tx_out_q    <= 1'b0;
      tx_dly_q    <= 1'b0;
      tx_inv_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tail_cnt_q  <= tail_cnt_d;
      delay_q     <= delay_d;
      delay_en_q  <= delay_en_d;
      invert_en_q <= invert_en_d;
      active_q    <= active_d;
      tx_out_q    <= tx_out_d;
      tx_dly_q    <= tx_dly_d;
      tx_inv_q    <= tx_inv_d;
    end
  end

  assign cfg_busy      = (state_q != ST_IDLE);
  assign active_output = active_q;
  assign tx_output     = tx_out_q;
  assign tx_delay      = tx_dly_q;
  assign tx_inverted   = tx_inv_q;

endmodule

// File: tb/tb_coax_tx_predistorter.sv
// Self-checking bench for coax_tx_predistorter (CLOCKS_PER_BIT=8,
// MAX_DELAY_CLOCKS=8, TAIL_CLOCKS=4). The reference model works on the
// frame level: a history of the bits fed to the line since the frame began
// (1s before it), a remaining-tail count, and "busy equals driver active".
module tb_coax_tx_predistorter;

  localparam int TAIL = 4;
  localparam int MAXD = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       active_input = 1'b0;
  logic       tx_input = 1'b0;
  logic       cfg_load = 1'b0;
  logic [3:0] cfg_delay = 4'd0;
  logic       cfg_delay_en = 1'b0;
  logic       cfg_invert_en = 1'b0;
  logic       cfg_busy;
  logic       active_output;
  logic       tx_output;
  logic       tx_delay;
  logic       tx_inverted;

  coax_tx_predistorter #(
    .CLOCKS_PER_BIT   (8),
    .MAX_DELAY_CLOCKS (MAXD),
    .TAIL_CLOCKS      (TAIL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .active_input  (active_input),
    .tx_input      (tx_input),
    .cfg_load      (cfg_load),
    .cfg_delay     (cfg_delay),
    .cfg_delay_en  (cfg_delay_en),
    .cfg_invert_en (cfg_invert_en),
    .cfg_busy      (cfg_busy),
    .active_output (active_output),
    .tx_output     (tx_output),
    .tx_delay      (tx_delay),
    .tx_inverted   (tx_inverted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int   m_delay   = 2;
  bit   m_den     = 1'b1;
  bit   m_ien     = 1'b1;
  bit   fed[$];
  int   tail_left = 0;
  bit   prev_ain  = 1'b0;
  bit   e_act = 1'b0, e_out = 1'b0, e_dly = 1'b0, e_inv = 1'b0;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  function automatic bit delayed_bit(input bit now);
    if (m_delay == 0) return now;
    if (fed.size() >= m_delay) return fed[fed.size() - m_delay];
    return 1'b1;
  endfunction

  // One clock: drive inputs, update the model, compare all outputs.
  task automatic cyc(input bit rst, input bit ain, input bit tx, input bit ld,
                     input logic [3:0] d, input bit den, input bit ien);
    bit fb;
    reset = rst; active_input = ain; tx_input = tx;
    cfg_load = ld; cfg_delay = d; cfg_delay_en = den; cfg_invert_en = ien;
    @(posedge clk);
    if (rst) begin
      m_delay = 2; m_den = 1'b1; m_ien = 1'b1;
      fed.delete(); tail_left = 0; prev_ain = 1'b0;
      e_act = 0; e_out = 0; e_dly = 0; e_inv = 0;
    end else begin
      if (ld && !e_act) begin
        m_delay = (int'(d) > MAXD) ? MAXD : int'(d);
        m_den = den; m_ien = ien;
      end
      if (ain) begin
        if (!e_act) fed.delete();
        e_dly = delayed_bit(tx) & m_den;
        e_out = tx; e_inv = ~tx & m_ien; e_act = 1'b1;
        fed.push_back(tx);
      end else begin
        if (prev_ain) tail_left = TAIL;
        if (e_act && tail_left > 0) begin
          fb = e_out;
          e_dly = delayed_bit(fb) & m_den;
          fed.push_back(fb);
          tail_left--;
        end else begin
          e_act = 0; e_out = 0; e_dly = 0; e_inv = 0;
          fed.delete(); tail_left = 0;
        end
      end
      if (fed.size() > 32) void'(fed.pop_front());
      prev_ain = ain;
    end
    #1;
    check("active_output", active_output, e_act);
    check("tx_output", tx_output, e_out);
    check("tx_delay", tx_delay, e_dly);
    check("tx_inverted", tx_inverted, e_inv);
    check("cfg_busy", cfg_busy, e_act);
    $display("t=%0t rst=%0b ain=%0b tx=%0b ld=%0b -> act=%0b out=%0b dly=%0b inv=%0b busy=%0b",
             $time, rst, ain, tx, ld, active_output, tx_output, tx_delay, tx_inverted, cfg_busy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 4'd0, 0, 0);
  endtask

  task automatic frame_rand(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 1'($urandom_range(0, 1)), 0, 4'd0, 0, 0);
  endtask

  task automatic load(input logic [3:0] d, input bit den, input bit ien);
    cyc(0, 0, 0, 1, d, den, ien);
  endtask

  initial begin
    // Reset state
    cyc(1, 0, 0, 0, 4'd0, 0, 0);
    cyc(1, 0, 0, 0, 4'd0, 0, 0);
    idle(2);

    // Default config: 1010 pattern, 8 clocks per bit, delay 2
    for (int i = 0; i < 16; i++) cyc(0, 1, ((i / 8) % 2) == 0, 0, 4'd0, 0, 0);
    idle(8);

    // Programmed delay 5, then clamp of 15 to 8
    load(4'd5, 1, 1);
    frame_rand(20);
    idle(8);
    load(4'd15, 1, 1);
    frame_rand(20);
    idle(8);

    // Zero delay and per-output enables
    load(4'd0, 1, 1);
    frame_rand(12);
    idle(8);
    load(4'd3, 0, 1);
    frame_rand(12);
    idle(8);
    load(4'd3, 1, 0);
    frame_rand(12);
    idle(8);

    // Config load in the same cycle as the first active clock
    cyc(0, 1, 0, 1, 4'd1, 1, 1);
    frame_rand(10);
    // Frame ending on a 0 bit: tail holds tx_output=0, tx_inverted=1
    cyc(0, 1, 0, 0, 4'd0, 0, 0);
    idle(8);

    // Re-assert during the tail; loads while busy must be dropped
    load(4'd4, 1, 1);
    frame_rand(10);
    idle(2);
    for (int i = 0; i < 10; i++)
      cyc(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle(4);
    frame_rand(12);
    idle(8);

    // Reset in the middle of a frame with a non-default config
    load(4'd6, 0, 0);
    frame_rand(6);
    cyc(1, 1, 1, 0, 4'd0, 0, 0);
    idle(3);
    frame_rand(12);
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
